// File: rtl/pixel_pack_fifo.sv
// rtl/pixel_pack_fifo.sv - packing FIFO: RATIO write words form one read word, optional FWFT
module pixel_pack_fifo #(
   parameter int WR_DATA_WIDTH    = 16,
   parameter int RATIO            = 2,
   parameter int DEPTH_WIDTH      = 9,
   parameter int FWFT             = 0,
   parameter int ALMOST_FULL_NUM  = 508,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [WR_DATA_WIDTH-1:0]         wr_data,
   input  logic                             wr_en,
   output logic                             wr_full,
   input  logic                             flush,
   input  logic                             rd_en,
   output logic [WR_DATA_WIDTH*RATIO-1:0]   rd_data,
   output logic                             rd_empty,
   output logic [DEPTH_WIDTH:0]             water_level,
   output logic                             almost_full,
   output logic                             almost_empty,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int RD_W       = WR_DATA_WIDTH * RATIO;
   localparam int DEPTH      = 1 << DEPTH_WIDTH;
   localparam int CNT_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int PACK_SLOTS = (RATIO > 1) ? RATIO - 1 : 1;

   localparam logic [CNT_W-1:0]       LAST_SLOT  = CNT_W'(RATIO - 1);
   localparam logic [DEPTH_WIDTH:0]   FULL_LEVEL = (DEPTH_WIDTH + 1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0]   AF_LEVEL   = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
   localparam logic [DEPTH_WIDTH:0]   AE_LEVEL   = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

   logic [RD_W-1:0]                       mem [DEPTH];
   logic [WR_DATA_WIDTH*PACK_SLOTS-1:0]   pack_reg;
   logic [CNT_W-1:0]                      pack_cnt;
   // Pointers carry one extra bit so a full RAM is distinguishable from an empty one.
   logic [DEPTH_WIDTH:0]                  wr_ptr;
   logic [DEPTH_WIDTH:0]                  wr_ptr_q;
   logic [DEPTH_WIDTH:0]                  rd_ptr;
   logic [DEPTH_WIDTH:0]                  level;
   logic                                  pf_valid;
   logic                                  pack_last;
   logic                                  wr_accept;
   logic                                  push;
   logic                                  pop;
   logic                                  fetch;
   logic                                  rd_load;
   logic [RD_W-1:0]                       push_word;

   assign pack_last    = (pack_cnt == LAST_SLOT);
   assign wr_full      = (level == FULL_LEVEL) && pack_last;
   assign wr_accept    = wr_en && !wr_full && !flush;
   assign push         = wr_accept && pack_last;
   assign rd_empty     = (FWFT != 0) ? !pf_valid : (level == '0);
   assign pop          = rd_en && !rd_empty && !flush;
   // Prefetch only words whose RAM write is at least one edge old, so the RAM
   // never sees a read and a write of the same address on the same edge.
   assign fetch        = (!pf_valid || pop) && (rd_ptr != wr_ptr_q) && !flush;
   assign rd_load      = (FWFT != 0) ? fetch : pop;
   assign water_level  = level;
   assign almost_full  = (level >= AF_LEVEL);
   assign almost_empty = (level <= AE_LEVEL);

   // The completed read word is the held lower slots plus the incoming top slot.
   if (RATIO > 1) begin : g_pack
      assign push_word = {wr_data, pack_reg};
   end else begin : g_nopack
      assign push_word = wr_data;
   end

   // Capture accepted write words into their pack slot until the top slot arrives.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PACK_SLOTS; i++) begin
         if (wr_accept && !pack_last && (pack_cnt == CNT_W'(i))) begin
            pack_reg[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
         end
      end
   end

   // Simple dual-port RAM write side.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[DEPTH_WIDTH-1:0]] <= push_word;
      end
   end

   // RAM read side: registered output, loaded on a pop (standard) or a prefetch (FWFT).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_load) begin
         rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
      end
   end

   // Pointers, occupancy, pack counter, prefetch state and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pack_cnt  <= '0;
         pf_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && wr_full && !flush) begin
            overflow <= 1'b1;
         end
         if (rd_en && rd_empty && !flush) begin
            underflow <= 1'b1;
         end
         if (flush) begin
            wr_ptr   <= '0;
            wr_ptr_q <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pack_cnt <= '0;
            pf_valid <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr;
            if (wr_accept) begin
               pack_cnt <= pack_last ? '0 : pack_cnt + CNT_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_load) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (fetch) begin
               pf_valid <= 1'b1;
            end else if (pop) begin
               pf_valid <= 1'b0;
            end
            case ({push, pop})
               2'b10:   level <= level + 1'b1;
               2'b01:   level <= level - 1'b1;
               default: level <= level;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// tb/tb_pixel_pack_fifo.sv - self-checking bench for pixel_pack_fifo (standard and FWFT)
module tb_pixel_pack_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en0 = 1'b0;
   logic        rd_en1 = 1'b0;
   logic [15:0] wr_data = '0;

   logic        wr_full0, rd_empty0, af0, ae0, ovf0, unf0;
   logic        wr_full1, rd_empty1, af1, ae1, ovf1, unf1;
   logic [31:0] rd_data0, rd_data1;
   logic [4:0]  level0, level1;

   always #5 clk = ~clk;

   pixel_pack_fifo #(
      .WR_DATA_WIDTH(16), .RATIO(2), .DEPTH_WIDTH(4), .FWFT(0),
      .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
   ) u_dut0 (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full0),
      .flush(flush), .rd_en(rd_en0), .rd_data(rd_data0), .rd_empty(rd_empty0),
      .water_level(level0), .almost_full(af0), .almost_empty(ae0),
      .overflow(ovf0), .underflow(unf0)
   );

   pixel_pack_fifo #(
      .WR_DATA_WIDTH(16), .RATIO(2), .DEPTH_WIDTH(4), .FWFT(1),
      .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
   ) u_dut1 (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full1),
      .flush(flush), .rd_en(rd_en1), .rd_data(rd_data1), .rd_empty(rd_empty1),
      .water_level(level1), .almost_full(af1), .almost_empty(ae1),
      .overflow(ovf1), .underflow(unf1)
   );

   int errors = 0;
   int checks = 0;

   // Reference model of the standard-read instance.
   logic [31:0] sbq[$];
   int          m_cnt;
   logic [15:0] m_lo;
   logic        m_ovf, m_unf;
   logic [31:0] m_rd;

   typedef struct {
      logic        wr;
      logic [15:0] d;
      logic        rd;
      logic        fl;
      logic [4:0]  lvl;
      logic        empty;
      logic        chk_rd;
      logic [31:0] rd_exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic wr, input logic [15:0] d, input logic rd,
                               input logic fl, input logic [4:0] lvl, input logic empty,
                               input logic chk_rd, input logic [31:0] rd_exp);
      vec_t v;
      v.wr = wr; v.d = d; v.rd = rd; v.fl = fl;
      v.lvl = lvl; v.empty = empty; v.chk_rd = chk_rd; v.rd_exp = rd_exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic wr, input logic [15:0] d, input logic rd0,
                       input logic rd1, input logic fl);
      bit full;
      bit do_pop;
      int lvl;
      full   = (sbq.size() == 16) && (m_cnt == 1);
      do_pop = rd0 && (sbq.size() != 0) && !fl;
      if (rd0 && (sbq.size() == 0) && !fl) m_unf = 1'b1;
      if (do_pop) m_rd = sbq.pop_front();
      if (fl) begin
         sbq.delete();
         m_cnt = 0;
      end else if (wr && full) begin
         m_ovf = 1'b1;
      end else if (wr) begin
         if (m_cnt == 0) begin
            m_lo  = d;
            m_cnt = 1;
         end else begin
            sbq.push_back({d, m_lo});
            m_cnt = 0;
         end
      end
      wr_en = wr; wr_data = d; rd_en0 = rd0; rd_en1 = rd1; flush = fl;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0; flush = 1'b0;
      lvl = sbq.size();
      chk("m_level",   32'(level0),    32'(lvl));
      chk("m_empty",   32'(rd_empty0), 32'(lvl == 0));
      chk("m_full",    32'(wr_full0),  32'((lvl == 16) && (m_cnt == 1)));
      chk("m_afull",   32'(af0),       32'(lvl >= 14));
      chk("m_aempty",  32'(ae0),       32'(lvl <= 2));
      chk("m_ovf",     32'(ovf0),      32'(m_ovf));
      chk("m_unf",     32'(unf0),      32'(m_unf));
      chk("m_rd_data", rd_data0,       m_rd);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0; flush = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      sbq.delete();
      m_cnt = 0; m_lo = '0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;
      chk("rst0_empty", 32'(rd_empty0), 32'd1);
      chk("rst0_full",  32'(wr_full0),  32'd0);
      chk("rst0_level", 32'(level0),    32'd0);
      chk("rst0_ae",    32'(ae0),       32'd1);
      chk("rst0_af",    32'(af0),       32'd0);
      chk("rst0_ovf",   32'(ovf0),      32'd0);
      chk("rst0_unf",   32'(unf0),      32'd0);
      chk("rst0_data",  rd_data0,       32'd0);
      chk("rst1_empty", 32'(rd_empty1), 32'd1);
      chk("rst1_full",  32'(wr_full1),  32'd0);
      chk("rst1_level", 32'(level1),    32'd0);
      chk("rst1_ae",    32'(ae1),       32'd1);
      chk("rst1_af",    32'(af1),       32'd0);
      chk("rst1_ovf",   32'(ovf1),      32'd0);
      chk("rst1_unf",   32'(unf1),      32'd0);
      chk("rst1_data",  rd_data1,       32'd0);
   endtask

   initial begin
      // Basic pack/read, flush, underflow and simultaneous push/pop vectors.
      tbl.push_back(mk(1, 16'h1111, 0, 0, 5'd0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 16'h2222, 0, 0, 5'd1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 16'h0000, 1, 0, 5'd0, 1, 1, 32'h22221111));
      tbl.push_back(mk(1, 16'h3333, 0, 0, 5'd0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 16'h4444, 0, 0, 5'd1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 16'h5555, 0, 0, 5'd1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 5'd0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 16'h0001, 0, 0, 5'd0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 16'h0002, 0, 0, 5'd1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 16'h0000, 1, 0, 5'd0, 1, 1, 32'h00020001));
      tbl.push_back(mk(0, 16'h0000, 1, 0, 5'd0, 1, 1, 32'h00020001));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 5'd0, 1, 1, 32'h00020001));
      tbl.push_back(mk(1, 16'h0a0a, 0, 0, 5'd0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 16'h0b0b, 0, 0, 5'd1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 16'h0c0c, 0, 0, 5'd1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 16'h0d0d, 1, 0, 5'd1, 0, 1, 32'h0b0b0a0a));
      tbl.push_back(mk(0, 16'h0000, 1, 0, 5'd0, 1, 1, 32'h0d0d0c0c));

      do_reset(2);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0, tbl[i].fl);
         chk($sformatf("tbl%0d_level", i), 32'(level0), 32'(tbl[i].lvl));
         chk($sformatf("tbl%0d_empty", i), 32'(rd_empty0), 32'(tbl[i].empty));
         if (tbl[i].chk_rd) chk($sformatf("tbl%0d_data", i), rd_data0, tbl[i].rd_exp);
      end
      chk("unf_sticky_after_flush", 32'(unf0), 32'd1);

      // Reset mid-operation discards stored words and the partial pack.
      step(1, 16'h00e1, 0, 0, 0);
      step(1, 16'h00e2, 0, 0, 0);
      step(1, 16'h00e3, 0, 0, 0);
      do_reset(2);
      step(1, 16'h4444, 0, 0, 0);
      step(1, 16'h5555, 0, 0, 0);
      step(0, 16'h0000, 1, 0, 0);
      chk("post_rst_data", rd_data0, 32'h55554444);

      // Fill to full, overflow, then drain in order.
      for (int i = 0; i < 32; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
      chk("fill32_full",  32'(wr_full0), 32'd0);
      chk("fill32_level", 32'(level0),   32'd16);
      step(1, 16'h0120, 0, 0, 0);
      chk("fill33_full",  32'(wr_full0), 32'd1);
      chk("fill33_af",    32'(af0),      32'd1);
      chk("fill33_level", 32'(level0),   32'd16);
      step(1, 16'hdead, 0, 0, 0);
      chk("ovf_set",      32'(ovf0),     32'd1);
      chk("ovf_level",    32'(level0),   32'd16);
      step(1, 16'hbeef, 1, 0, 0);
      chk("drain_first",  rd_data0,      32'h01010100);
      for (int i = 1; i < 16; i++) step(0, 16'h0000, 1, 0, 0);
      chk("drain_last",   rd_data0,      32'h011f011e);
      chk("drain_level",  32'(level0),   32'd0);
      step(1, 16'h7777, 0, 0, 0);
      step(0, 16'h0000, 1, 0, 0);
      chk("partial_kept", rd_data0,      32'h77770120);

      // First-word-fall-through latency and back-to-back pops.
      do_reset(2);
      step(1, 16'haaaa, 0, 0, 0);
      step(1, 16'hbbbb, 0, 0, 0);
      chk("fwft_e0_empty", 32'(rd_empty1), 32'd1);
      chk("fwft_e0_level", 32'(level1),    32'd1);
      step(0, 16'h0000, 0, 0, 0);
      chk("fwft_e1_empty", 32'(rd_empty1), 32'd1);
      step(0, 16'h0000, 0, 0, 0);
      chk("fwft_e2_empty", 32'(rd_empty1), 32'd0);
      chk("fwft_e2_data",  rd_data1,       32'hbbbbaaaa);
      chk("fwft_e2_level", 32'(level1),    32'd1);
      step(1, 16'hcccc, 0, 0, 0);
      step(1, 16'hdddd, 0, 0, 0);
      step(1, 16'heeee, 0, 0, 0);
      step(1, 16'hffff, 0, 0, 0);
      step(0, 16'h0000, 0, 0, 0);
      step(0, 16'h0000, 0, 0, 0);
      chk("fwft_level3",   32'(level1),    32'd3);
      step(0, 16'h0000, 0, 1, 0);
      chk("fwft_pop1_data",  rd_data1,       32'hddddcccc);
      chk("fwft_pop1_empty", 32'(rd_empty1), 32'd0);
      chk("fwft_pop1_level", 32'(level1),    32'd2);
      step(0, 16'h0000, 0, 1, 0);
      chk("fwft_pop2_data",  rd_data1,       32'hffffeeee);
      chk("fwft_pop2_empty", 32'(rd_empty1), 32'd0);
      step(0, 16'h0000, 0, 1, 0);
      chk("fwft_pop3_empty", 32'(rd_empty1), 32'd1);
      chk("fwft_pop3_level", 32'(level1),    32'd0);
      chk("fwft_pop3_data",  rd_data1,       32'hffffeeee);
      chk("fwft_pop3_unf",   32'(unf1),      32'd0);
      step(0, 16'h0000, 0, 1, 0);
      chk("fwft_unf",        32'(unf1),      32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
